response_collector: RTL and testbench
=====================================

Name: response_collector

Overview:
- Sits directly upstream of the reduction engine in the tswitch reduction path.
- Accepts a reduction command (tag, requesting port, participant mask) and captures one BF16 response per participating port, matched by tag.
- Once every participant has responded, replays the captured values in ascending port order on the engine's value_* interface, with value_last on the final one.
- Fixed drain order keeps the floating-point sum bit-reproducible regardless of response arrival order.

Parameters:
- NUM_PORTS, 4, number of switch ports; PORT_BITS = $clog2(NUM_PORTS) is a derived localparam.
- TIMEOUT_CYCLES, 1024, number of collect cycles with no progress before the command is aborted.
- DATA_WIDTH and TAG_WIDTH come from tswitch_pkg (16 and 8).

Ports:
- clk  in  1  clock; all logic on posedge clk only.
- rst_n  in  1  reset, synchronous, active-low; sampled on posedge clk.
- cmd_valid  in  1  reduction command present.
- cmd_ready  out  1  command accepted on cmd_valid&cmd_ready.
- cmd_tag  in  TAG_WIDTH  reduction tag.
- cmd_src_port  in  PORT_BITS  port that receives the result.
- cmd_mask  in  NUM_PORTS  participating ports, bit i = port i.
- rsp_valid  in  NUM_PORTS  per-port response valid.
- rsp_data  in  NUM_PORTS*DATA_WIDTH  per-port BF16 value; port i in slice [i*DATA_WIDTH +: DATA_WIDTH].
- rsp_tag  in  NUM_PORTS*TAG_WIDTH  per-port response tag, same slicing.
- rsp_ready  out  NUM_PORTS  per-port response accept.
- value_valid  out  1  to reduction engine.
- value_data  out  DATA_WIDTH  captured value.
- value_tag  out  TAG_WIDTH  current tag.
- value_last  out  1  final value of this reduction.
- value_src_port  out  PORT_BITS  current cmd_src_port.
- value_ready  in  1  from reduction engine.
- err_pulse  out  1  one-cycle error strobe.
- err_code  out  2  qualified by err_pulse: 01 = timeout, 10 = empty mask.
- busy  out  1  state != S_IDLE.

Behaviour:
- Registers: state, cur_tag, cur_src, cur_mask, got[NUM_PORTS], pend[NUM_PORTS], buf[NUM_PORTS][DATA_WIDTH], tmo_cnt of width $clog2(TIMEOUT_CYCLES+1), err_pulse, err_code.
- Reset, on any posedge with rst_n=0, including mid-operation:
  - state=S_IDLE; got, pend, tmo_cnt, err_pulse, err_code, cur_* cleared.
  - Outputs: cmd_ready=1, rsp_ready=0, value_valid=0, value_last=0, value_data/tag/src=0, busy=0, err_pulse=0.
  - Any partially collected or partially drained reduction is dropped; no value_last is emitted for it.
- S_IDLE:
  - cmd_ready=1.
  - On accept with cmd_mask!=0: latch tag, src and mask; got=0; tmo_cnt=0; go to S_COLLECT.
  - On accept with cmd_mask==0: stay in S_IDLE; next cycle err_pulse=1, err_code=10.
- S_COLLECT:
  - cmd_ready=0.
  - rsp_ready[i] = cur_mask[i] & ~got[i]; non-participants and already-captured ports see rsp_ready=0, so the sender holds.
  - On handshake i with rsp_tag[i]==cur_tag: buf[i]=data, got[i]=1, tmo_cnt=0.
  - On handshake i with a tag mismatch: the response is consumed and discarded (stale); got is unchanged and tmo_cnt still increments.
  - Multiple ports may be captured in the same cycle.
  - If got_next==cur_mask: pend=cur_mask, go to S_DRAIN. value_valid therefore rises the cycle after the final capture edge.
  - Otherwise, when tmo_cnt==TIMEOUT_CYCLES-1 and no matching capture occurs this cycle: go to S_IDLE, clear got, next cycle err_pulse=1, err_code=01.
  - A final capture in the timeout cycle means completion wins.
- S_DRAIN:
  - cmd_ready=0, rsp_ready=0.
  - ptr = index of lowest set bit of pend; value_valid=1, value_data=buf[ptr], value_tag=cur_tag, value_src_port=cur_src.
  - value_last = (pend has exactly one bit set).
  - Outputs stay stable while value_valid&~value_ready.
  - On handshake: clear pend[ptr]; if value_last, go to S_IDLE.
  - Single-participant mask: one beat with value_last=1.
- Throughput: a new command can be accepted the cycle after the last value handshake.
- err_pulse is high for exactly one cycle; err_code holds its value until the next error.

Test Plan:
- Mask 4'b1111, tag 8'h5A, responses arrive in port order 2,0,3,1 with values 3F80,4000,4040,4080 -> four beats in port order 0..3 carrying 4000,4080,3F80,4040; last only on beat 4; tag 5A.
- Mask 4'b0100, src 3, port 2 returns 4120 -> single beat 4120 with value_last=1, value_src_port=3; back in S_IDLE one cycle after the handshake.
- Port 1 first returns tag 8'h11 while cur_tag=8'h22, then returns tag 22 -> stale response consumed (rsp_ready=1 on it), only the tag-22 value is replayed.
- Mask 4'b0011, only port 0 responds, TIMEOUT_CYCLES=16 -> err_pulse with err_code=01 exactly 16 cycles after the last progress; no value_valid; cmd_ready=1 afterwards.
- value_ready held low for 5 cycles in S_DRAIN -> value_* stable throughout; cmd_mask=0 command -> err_code=10 and busy stays 0.
- rst_n low for one cycle mid-S_DRAIN after beat 1 of 4 -> next cycle value_valid=0, busy=0, cmd_ready=1; a new command then completes normally.

Source files
------------

// File: rtl/response_collector_if.sv
// Command, per-port response and value-replay bundle of the response collector.
interface response_collector_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 8
);
  localparam int PORT_BITS = $clog2(NUM_PORTS);

  logic                            cmd_valid;
  logic                            cmd_ready;
  logic [TAG_WIDTH-1:0]            cmd_tag;
  logic [PORT_BITS-1:0]            cmd_src_port;
  logic [NUM_PORTS-1:0]            cmd_mask;
  logic [NUM_PORTS-1:0]            rsp_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_data;
  logic [NUM_PORTS*TAG_WIDTH-1:0]  rsp_tag;
  logic [NUM_PORTS-1:0]            rsp_ready;
  logic                            value_valid;
  logic [DATA_WIDTH-1:0]           value_data;
  logic [TAG_WIDTH-1:0]            value_tag;
  logic                            value_last;
  logic [PORT_BITS-1:0]            value_src_port;
  logic                            value_ready;
  logic                            err_pulse;
  logic [1:0]                      err_code;
  logic                            busy;

  modport slave (
    input  cmd_valid, cmd_tag, cmd_src_port, cmd_mask, rsp_valid, rsp_data, rsp_tag, value_ready,
    output cmd_ready, rsp_ready, value_valid, value_data, value_tag, value_last, value_src_port,
           err_pulse, err_code, busy
  );

  modport master (
    output cmd_valid, cmd_tag, cmd_src_port, cmd_mask, rsp_valid, rsp_data, rsp_tag, value_ready,
    input  cmd_ready, rsp_ready, value_valid, value_data, value_tag, value_last, value_src_port,
           err_pulse, err_code, busy
  );
endinterface

// File: rtl/response_collector.sv
// Collects one tagged BF16 response per participating port, then replays them in
// ascending port order so the downstream sum is independent of arrival order.
package tswitch_pkg;
  parameter int DATA_WIDTH = 16;
  parameter int TAG_WIDTH  = 8;
endpackage

module rc_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  collecting,
  input  logic                  part,
  input  logic                  got,
  input  logic                  valid,
  input  logic [TAG_WIDTH-1:0]  tag,
  input  logic [TAG_WIDTH-1:0]  cur_tag,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  capture,
  output logic [DATA_WIDTH-1:0] value
);
  // Stale tags are still accepted (ready is tag-independent) so senders drain them.
  assign ready   = collecting & part & ~got;
  assign capture = ready & valid & (tag == cur_tag);

  always_ff @(posedge clk)
    if (capture) value <= data;
endmodule

module response_collector
  import tswitch_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  response_collector_if.slave bus
);
  localparam int PORT_BITS = $clog2(NUM_PORTS);
  localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

  state_t                               state, state_n;
  logic [TAG_WIDTH-1:0]                 cur_tag;
  logic [PORT_BITS-1:0]                 cur_src;
  logic [NUM_PORTS-1:0]                 cur_mask, got, pend, cap, rdy, got_next;
  logic [TMO_W-1:0]                     tmo_cnt;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] buf_q;
  logic [PORT_BITS-1:0]                 ptr;
  logic                                 collecting, all_got, tmo_hit, err_pulse_q;
  logic [1:0]                           err_code_q;

  assign collecting = (state == S_COLLECT);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    rc_lane #(.DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_lane (
      .clk        (clk),
      .collecting (collecting),
      .part       (cur_mask[i]),
      .got        (got[i]),
      .valid      (bus.rsp_valid[i]),
      .tag        (bus.rsp_tag[i*TAG_WIDTH +: TAG_WIDTH]),
      .cur_tag    (cur_tag),
      .data       (bus.rsp_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .ready      (rdy[i]),
      .capture    (cap[i]),
      .value      (buf_q[i])
    );
  end

  assign bus.rsp_ready = rdy;
  assign got_next      = got | cap;
  assign all_got       = (got_next == cur_mask);
  // A final capture in the last timeout cycle completes rather than aborts.
  assign tmo_hit       = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) & ~|cap;

  // Lowest pending port drains first.
  always_comb begin
    ptr = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (pend[i]) ptr = PORT_BITS'(i);
  end

  always_ff @(posedge clk)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;

  always_comb begin
    state_n            = state;
    bus.cmd_ready      = 1'b0;
    bus.value_valid    = 1'b0;
    bus.value_data     = '0;
    bus.value_tag      = '0;
    bus.value_src_port = '0;
    bus.value_last     = 1'b0;
    case (state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid && (bus.cmd_mask != '0)) state_n = S_COLLECT;
      end
      S_COLLECT: begin
        if (all_got)      state_n = S_DRAIN;
        else if (tmo_hit) state_n = S_IDLE;
      end
      S_DRAIN: begin
        bus.value_valid    = 1'b1;
        bus.value_data     = buf_q[ptr];
        bus.value_tag      = cur_tag;
        bus.value_src_port = cur_src;
        bus.value_last     = $onehot(pend);
        if (bus.value_ready && bus.value_last) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_tag     <= '0;
      cur_src     <= '0;
      cur_mask    <= '0;
      got         <= '0;
      pend        <= '0;
      tmo_cnt     <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      err_pulse_q <= 1'b0;
      case (state)
        S_IDLE:
          if (bus.cmd_valid) begin
            if (bus.cmd_mask != '0) begin
              cur_tag  <= bus.cmd_tag;
              cur_src  <= bus.cmd_src_port;
              cur_mask <= bus.cmd_mask;
              got      <= '0;
              tmo_cnt  <= '0;
            end else begin
              err_pulse_q <= 1'b1;
              err_code_q  <= 2'b10;
            end
          end
        S_COLLECT: begin
          got     <= got_next;
          tmo_cnt <= (|cap) ? '0 : tmo_cnt + 1'b1;
          if (all_got) begin
            pend <= cur_mask;
          end else if (tmo_hit) begin
            got         <= '0;
            err_pulse_q <= 1'b1;
            err_code_q  <= 2'b01;
          end
        end
        S_DRAIN:
          if (bus.value_ready) pend[ptr] <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.err_pulse = err_pulse_q;
  assign bus.err_code  = err_code_q;
  assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_response_collector.sv
// Randomized scoreboard bench for response_collector: a queue model of port-ordered replay.
module tb_response_collector;
  localparam int NP = 4, DW = 16, TW = 8, PB = 2, TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  response_collector_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();
  response_collector #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic [PB-1:0] src;
    logic          last;
  } beat_t;

  beat_t      exp_q[$];
  logic [1:0] err_q[$];
  int total = 0;
  int bad   = 0;
  bit rdy_force = 1'b1;
  bit rdy_val   = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: every participant replayed once, lowest port first, last on the highest.
  function automatic void model_cmd(input logic [TW-1:0] tag, input logic [PB-1:0] src,
                                    input logic [NP-1:0] mask, input logic [NP-1:0][DW-1:0] vals);
    if (mask == '0) begin
      err_q.push_back(2'b10);
      return;
    end
    for (int i = 0; i < NP; i++)
      if (mask[i]) begin
        beat_t b;
        b.data = vals[i];
        b.tag  = tag;
        b.src  = src;
        b.last = ((mask >> (i + 1)) == '0);
        exp_q.push_back(b);
      end
  endfunction

  always @(posedge clk) begin
    #1;
    bus.value_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (rst_n && bus.value_valid && bus.value_ready) begin
      logic [31:0] act;
      act = 32'({bus.value_data, bus.value_tag, bus.value_src_port, bus.value_last});
      if (exp_q.size() == 0) chk("unexpected_beat", act, 32'hFFFF_FFFF);
      else                   chk("beat", act, 32'(exp_q.pop_front()));
    end
    if (rst_n && bus.err_pulse) begin
      if (err_q.size() == 0) chk("unexpected_err", 32'(bus.err_code), 32'hFFFF_FFFF);
      else                   chk("err_code", 32'(bus.err_code), 32'(err_q.pop_front()));
    end
  end

  task automatic send_cmd(input logic [TW-1:0] tag, input logic [PB-1:0] src, input logic [NP-1:0] mask);
    int n = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_tag = tag; bus.cmd_src_port = src; bus.cmd_mask = mask;
    do begin @(negedge clk); n++; end while (!bus.cmd_ready && n < 200);
    chk("cmd_accept", 32'(bus.cmd_ready), 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic respond(input int p, input logic [TW-1:0] tag, input logic [DW-1:0] d);
    int n = 0;
    @(posedge clk); #1;
    bus.rsp_valid[p] = 1'b1;
    bus.rsp_tag[p*TW +: TW] = tag;
    bus.rsp_data[p*DW +: DW] = d;
    do begin @(negedge clk); n++; end while (!bus.rsp_ready[p] && n < 200);
    chk("rsp_accept", 32'(bus.rsp_ready[p]), 1);
    @(posedge clk); #1;
    bus.rsp_valid[p] = 1'b0;
  endtask

  // Random per-cycle responders; stale ports send one wrong-tag response first.
  task automatic collect_drive(input logic [NP-1:0] mask, input logic [TW-1:0] tag,
                               input logic [NP-1:0][DW-1:0] vals, input logic [NP-1:0] stale);
    logic [NP-1:0] pending, st;
    int n = 0;
    pending = mask;
    st = stale & mask;
    while (pending != '0 && n < 500) begin
      @(posedge clk); #1;
      for (int i = 0; i < NP; i++) begin
        bus.rsp_valid[i] = (pending[i] || !mask[i]) && ($urandom_range(0, 3) != 0);
        bus.rsp_tag[i*TW +: TW] = st[i] ? ~tag : tag;
        bus.rsp_data[i*DW +: DW] = mask[i] ? vals[i] : DW'($urandom);
      end
      @(negedge clk); n++;
      for (int i = 0; i < NP; i++)
        if (bus.rsp_valid[i]) begin
          if (!mask[i]) chk("nonpart_ready", 32'(bus.rsp_ready[i]), 0);
          else if (bus.rsp_ready[i]) begin
            if (st[i]) st[i] = 1'b0;
            else       pending[i] = 1'b0;
          end
        end
    end
    chk("collect_done", 32'(pending), 0);
    @(posedge clk); #1;
    bus.rsp_valid = '0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (bus.busy && n < 1000);
    chk(name, 32'(bus.busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [NP-1:0][DW-1:0] v;
    logic [31:0] snap, cur;
    int hit;
    logic [NP-1:0] m;
    logic [TW-1:0] tg;
    logic [PB-1:0] sp;

    bus.cmd_valid = 1'b0; bus.cmd_tag = '0; bus.cmd_src_port = '0; bus.cmd_mask = '0;
    bus.rsp_valid = '0; bus.rsp_tag = '0; bus.rsp_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_rsp_ready", 32'(bus.rsp_ready), 0);
    chk("rst_value_valid", 32'(bus.value_valid), 0);
    chk("rst_value_last", 32'(bus.value_last), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'({bus.err_pulse, bus.err_code}), 0);
    chk("rst_value_fields", 32'({bus.value_data, bus.value_tag, bus.value_src_port}), 0);

    // Out-of-order arrival, in-order replay.
    v[0] = 16'h4000; v[1] = 16'h4080; v[2] = 16'h3F80; v[3] = 16'h4040;
    model_cmd(8'h5A, 2'd0, 4'b1111, v);
    send_cmd(8'h5A, 2'd0, 4'b1111);
    respond(2, 8'h5A, 16'h3F80);
    respond(0, 8'h5A, 16'h4000);
    respond(3, 8'h5A, 16'h4040);
    respond(1, 8'h5A, 16'h4080);
    wait_idle("t1_idle");
    chk("t1_drained", exp_q.size(), 0);

    // Single participant: one last beat, idle one cycle after the handshake.
    v = '0; v[2] = 16'h4120;
    model_cmd(8'h33, 2'd3, 4'b0100, v);
    send_cmd(8'h33, 2'd3, 4'b0100);
    respond(2, 8'h33, 16'h4120);
    @(negedge clk);
    chk("t2_valid", 32'(bus.value_valid), 1);
    @(negedge clk);
    chk("t2_busy", 32'(bus.busy), 0);
    chk("t2_cmd_ready", 32'(bus.cmd_ready), 1);

    // Stale tag consumed and dropped.
    v = '0; v[1] = 16'h4188;
    model_cmd(8'h22, 2'd1, 4'b0010, v);
    send_cmd(8'h22, 2'd1, 4'b0010);
    respond(1, 8'h11, 16'hDEAD);
    respond(1, 8'h22, 16'h4188);
    wait_idle("t3_idle");

    // Timeout: err 16 cycles after the only capture.
    err_q.push_back(2'b01);
    send_cmd(8'h44, 2'd0, 4'b0011);
    respond(0, 8'h44, 16'h1234);
    hit = -1;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      if (bus.err_pulse && hit < 0) hit = n;
    end
    chk("t4_tmo_cycle", hit, 16);
    chk("t4_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("t4_busy", 32'(bus.busy), 0);

    // Backpressure: outputs hold while value_ready is low.
    rdy_val = 1'b0;
    for (int i = 0; i < NP; i++) v[i] = DW'($urandom);
    model_cmd(8'h5C, 2'd2, 4'b1111, v);
    send_cmd(8'h5C, 2'd2, 4'b1111);
    collect_drive(4'b1111, 8'h5C, v, 4'b0000);
    @(negedge clk);
    chk("t5_valid", 32'(bus.value_valid), 1);
    snap = 32'({bus.value_data, bus.value_tag, bus.value_src_port, bus.value_last});
    chk("t5_first", snap, 32'({v[0], 8'h5C, 2'd2, 1'b0}));
    repeat (5) begin
      @(negedge clk);
      cur = 32'({bus.value_data, bus.value_tag, bus.value_src_port, bus.value_last});
      chk("t5_stable", cur, snap);
    end
    rdy_val = 1'b1;
    wait_idle("t5_idle");

    // Empty mask reports error without leaving idle.
    model_cmd(8'h77, 2'd0, 4'b0000, v);
    send_cmd(8'h77, 2'd0, 4'b0000);
    repeat (3) begin
      @(negedge clk);
      chk("t5_mask0_busy", 32'(bus.busy), 0);
    end

    // Reset after the first drained beat drops the rest.
    rdy_val = 1'b0;
    for (int i = 0; i < NP; i++) v[i] = DW'($urandom);
    model_cmd(8'h66, 2'd1, 4'b1111, v);
    send_cmd(8'h66, 2'd1, 4'b1111);
    collect_drive(4'b1111, 8'h66, v, 4'b0000);
    @(negedge clk);
    chk("t6_valid", 32'(bus.value_valid), 1);
    rdy_val = 1'b1;
    @(negedge clk);
    rdy_val = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_value_valid", 32'(bus.value_valid), 0);
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("t6_left", exp_q.size(), 3);
    exp_q.delete();
    rdy_val = 1'b1;
    for (int i = 0; i < NP; i++) v[i] = DW'($urandom);
    model_cmd(8'h67, 2'd0, 4'b1010, v);
    send_cmd(8'h67, 2'd0, 4'b1010);
    collect_drive(4'b1010, 8'h67, v, 4'b0000);
    wait_idle("t6_after_idle");

    // Random traffic with stale responses and random backpressure.
    rdy_force = 1'b0;
    for (int t = 0; t < 40; t++) begin
      m  = NP'($urandom_range(0, 15));
      tg = TW'($urandom);
      sp = PB'($urandom);
      for (int i = 0; i < NP; i++) v[i] = DW'($urandom);
      model_cmd(tg, sp, m, v);
      send_cmd(tg, sp, m);
      if (m != '0) collect_drive(m, tg, v, NP'($urandom));
      wait_idle("rand_idle");
    end

    repeat (5) @(negedge clk);
    chk("end_beats_empty", exp_q.size(), 0);
    chk("end_errs_empty", err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
